icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, blocking instruction cache directly upstream of the instruction fetch queue.
- Accepts a fetch address with a read strobe and returns one aligned 128-bit line (4 instructions) with a one-cycle valid pulse.
- On a miss, fetches the line from the next memory level over a single-beat req/valid handshake.
- Supports request abort on branch redirect and a whole-cache invalidate.

Parameters:
- LINES, 64, number of cache lines; power of 2, ≥2; IDX = log2(LINES).
- TAG_W, 28-IDX, tag width = pc_in[31:4+IDX].

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- pc_in  input  32  fetch byte address; [3:0] ignored, [4+IDX-1:4] index, [31:4+IDX] tag
- cache_rd_en  input  1  fetch request strobe
- cache_abort  input  1  cancel outstanding request; no dout_valid for it
- inv_all  input  1  clear all valid bits
- dout  output  128  line data; word k at [32k+31:32k]
- dout_valid  output  1  one-cycle pulse, dout valid this cycle
- busy  output  1  high when a new cache_rd_en is not accepted this cycle
- mem_req  output  1  line fill request, held until mem_valid
- mem_addr  output  32  line-aligned fill address, [3:0]=0
- mem_rdata  input  128  fill data
- mem_valid  input  1  fill data valid, single beat

Behaviour:
- Reset (async, any state) sets:
  - state IDLE, all valid bits 0
  - dout=0, dout_valid=0, mem_req=0, mem_addr=0, busy=0, abort_flag=0
- Tag/data/valid arrays are flop-based; reset does not clear tag/data.
- Request acceptance:
  - A request is accepted when cache_rd_en=1, cache_abort=0 and busy=0.
  - On acceptance pc_in is latched into req_addr.
  - cache_abort in the same cycle as cache_rd_en: request dropped.
- busy = (state==MISS) | (state==FILL) | (state==LOOKUP & miss).
- IDLE:
  - accept → LOOKUP.
- LOOKUP:
  - Compares valid[idx] & tag[idx]==req_tag, combinationally from req_addr.
  - Hit, cache_abort=0: dout=data[idx] and dout_valid=1 in this cycle (latency 1 after the accept edge). A new accepted request stays in LOOKUP; otherwise go to IDLE. This gives one hit per cycle throughput.
  - Hit, cache_abort=1: no dout_valid; → IDLE, or stay in LOOKUP if a request is accepted in this cycle.
  - Miss: mem_addr={req_addr[31:4],4'b0}; mem_req=1 from the next cycle; → MISS. If cache_abort=1, abort_flag is set.
- MISS:
  - mem_req and mem_addr are held stable until mem_valid.
  - cache_abort in MISS sets abort_flag; the fill is not cancelled.
  - On mem_valid:
    - write data[idx]=mem_rdata and tag[idx]
    - set valid[idx]=1 unless inv_all is high this cycle
    - register mem_rdata into dout
    - mem_req=0 next cycle
    - → FILL
- FILL (one cycle):
  - dout_valid=1 if abort_flag=0 and cache_abort=0, else 0.
  - Clear abort_flag; → IDLE.
  - Miss latency = 1 (LOOKUP) + 1 (req) + memory wait + 1 (FILL) cycles after accept.
- dout holds its last value when dout_valid=0. dout_valid is never high for two cycles from one request.
- inv_all:
  - Clears every valid bit at the next edge, in any state.
  - If coincident with a LOOKUP, that lookup uses pre-clear valid bits.
- Conflict: a fill overwrites the line at the same index unconditionally.
- mem_valid outside MISS is ignored.

Test Plan:
- Cold miss: reset, cache_rd_en with pc_in=0x0000_1040 → mem_req=1, mem_addr=0x0000_1040. Drive mem_valid 3 cycles later with rdata=0xDDDD..CCCC..BBBB..AAAA → one dout_valid pulse with that data in the FILL cycle; busy low afterwards.
- Hit: after the cold miss, cache_rd_en pc_in=0x0000_1048 → dout_valid exactly one cycle after accept with the same line; mem_req stays 0. Back-to-back hits on 4 consecutive cycles → 4 consecutive dout_valid pulses.
- Conflict miss: LINES=64; fill 0x0000_1040, then request 0x0000_1440 (same index, new tag) → mem_req with mem_addr=0x0000_1440. A re-request of 0x0000_1040 then misses again.
- Abort mid-miss: miss on 0x2000, pulse cache_abort during MISS → fill completes, no dout_valid. A following request to 0x2000 hits with no mem_req.
- Invalidate: fill 0x3000, pulse inv_all, request 0x3000 → miss, mem_req=1. inv_all coincident with mem_valid → line not valid afterwards.
- Reset mid-miss: assert reset while mem_req=1 → mem_req, dout_valid and busy go to 0 immediately (async). A later mem_valid is ignored, and a re-request misses.

Source files
------------

// File: rtl/icache_dm.sv
// ----------------------------------------------------------------------------
// icache_dm
// Direct-mapped, blocking instruction cache that sits in front of the fetch
// queue. Every fetch returns one aligned 128-bit line (four instructions).
// Misses are filled from the next memory level with a single-beat handshake.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   pc_in        fetch byte address: [3:0] ignored, [4+IDX-1:4] index,
//                [31:4+IDX] tag
//   cache_rd_en  fetch request strobe
//   cache_abort  cancel the outstanding request (no dout_valid for it)
//   inv_all      clear every valid bit at the next edge
//   dout         line data, word k at [32k+31:32k]; holds when not valid
//   dout_valid   one-cycle pulse marking dout as valid
//   busy         high when a new cache_rd_en cannot be accepted this cycle
//   mem_req      line fill request, held until mem_valid
//   mem_addr     line-aligned fill address
//   mem_rdata    fill data
//   mem_valid    fill data valid (single beat)
// ----------------------------------------------------------------------------
module icache_dm #(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_in,
    input  logic         cache_rd_en,
    input  logic         cache_abort,
    input  logic         inv_all,
    output logic [127:0] dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_valid
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL
    } state_t;

    state_t             state;
    logic [27:0]        req_line;
    logic               abort_flag;
    logic [127:0]       dout_q;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [127:0]       data_mem [LINES];

    logic [IDX-1:0]     req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               lookup_hit;
    logic               lookup_miss;
    logic               accept;
    logic               hit_out;
    logic               fill_out;
    logic               fill_we;

    // Byte offset within a line never affects which line is returned.
    logic               unused_offset;
    assign unused_offset = ^pc_in[3:0];

    // Only the line address of a request is kept; the offset is irrelevant.
    assign req_idx = req_line[IDX-1:0];
    assign req_tag = req_line[27:IDX];

    // Tag match uses the registered valid bits, so an inv_all arriving in the
    // same cycle as a lookup only takes effect for later lookups.
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lookup_hit  = (state == LOOKUP) && hit;
    assign lookup_miss = (state == LOOKUP) && !hit;

    // A hit in LOOKUP can accept the next fetch in the same cycle, which is
    // what gives one hit per cycle throughput.
    assign busy   = (state == MISS) || (state == FILL) || lookup_miss;
    assign accept = cache_rd_en && !cache_abort && !busy;

    // Hit data is returned combinationally in the LOOKUP cycle; fill data was
    // registered into dout_q on the mem_valid edge and shows up in FILL.
    assign hit_out    = lookup_hit && !cache_abort;
    assign fill_out   = (state == FILL) && !abort_flag && !cache_abort;
    assign dout_valid = hit_out || fill_out;
    assign dout       = hit_out ? data_mem[req_idx] : dout_q;

    assign fill_we = (state == MISS) && mem_valid;

    // Control FSM, request latch, registered fill interface and valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_line   <= '0;
            abort_flag <= 1'b0;
            dout_q     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            valid      <= '0;
        end else begin
            if (accept) begin
                req_line <= pc_in[31:4];
            end

            // Remember delivered hit data so dout holds it afterwards.
            if (hit_out) begin
                dout_q <= data_mem[req_idx];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= accept ? LOOKUP : IDLE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {req_line, 4'b0000};
                        if (cache_abort) begin
                            abort_flag <= 1'b1;
                        end
                        state <= MISS;
                    end
                end
                MISS: begin
                    // An abort here only suppresses delivery; the fill still
                    // completes so the line ends up cached.
                    if (cache_abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (mem_valid) begin
                        dout_q  <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Invalidate wins over a coincident fill.
            if (inv_all) begin
                valid <= '0;
            end else if (fill_we) begin
                valid[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage is not reset; the valid bits alone qualify it.
    // A fill overwrites whatever line currently occupies the index.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[req_idx] <= mem_rdata;
            tag_mem[req_idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// ----------------------------------------------------------------------------
// tb_icache_dm
// Self-checking bench for icache_dm. A reference model keeps, per cache slot,
// a valid flag, the full line address stored there and its data; hit/miss and
// returned data are predicted from that model.
// ----------------------------------------------------------------------------
module tb_icache_dm;

    localparam int LINES = 64;

    logic         clk;
    logic         reset;
    logic [31:0]  pc_in;
    logic         cache_rd_en;
    logic         cache_abort;
    logic         inv_all;
    logic [127:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: what the cache should hold in each slot.
    bit           mv    [LINES];
    logic [31:0]  mline [LINES];
    logic [127:0] md    [LINES];

    icache_dm #(.LINES(LINES)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .cache_rd_en (cache_rd_en),
        .cache_abort (cache_abort),
        .inv_all     (inv_all),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled a little after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    function automatic int slotOf(input logic [31:0] addr);
        return int'((addr >> 4) % LINES);
    endfunction

    function automatic bit modelHit(input logic [31:0] addr);
        int s;
        s = slotOf(addr);
        return mv[s] && (mline[s] == (addr >> 4));
    endfunction

    // One complete fetch: hit or miss as predicted by the model, with the
    // memory answering waitCyc cycles after mem_req rises.
    task automatic applyStimulus(input logic [31:0] addr, input int waitCyc,
                                 input bit abortMiss, input bit invFill);
        int           s;
        int           w;
        bit           expHit;
        logic [127:0] rdata;
        s      = slotOf(addr);
        expHit = modelHit(addr);
        w      = (abortMiss && waitCyc < 1) ? 1 : waitCyc;

        cache_rd_en = 1'b1;
        pc_in       = addr;
        #1;
        checkBit("accept_busy", busy, 1'b0);
        step();
        cache_rd_en = 1'b0;
        pc_in       = $urandom;
        #1;
        if (expHit) begin
            checkBit("hit_valid", dout_valid, 1'b1);
            checkOutput("hit_data", dout, md[s]);
            checkBit("hit_memreq", mem_req, 1'b0);
            step();
            #1;
            checkBit("hit_single_pulse", dout_valid, 1'b0);
        end else begin
            checkBit("lookup_miss_valid", dout_valid, 1'b0);
            checkBit("lookup_miss_busy", busy, 1'b1);
            step();
            for (int i = 0; i < w; i++) begin
                cache_abort = abortMiss && (i == 0);
                #1;
                checkBit("miss_req", mem_req, 1'b1);
                checkWord("miss_addr", mem_addr, {addr[31:4], 4'h0});
                checkBit("miss_valid", dout_valid, 1'b0);
                step();
                cache_abort = 1'b0;
            end
            rdata     = {$urandom, $urandom, $urandom, $urandom};
            mem_valid = 1'b1;
            mem_rdata = rdata;
            inv_all   = invFill;
            step();
            mem_valid = 1'b0;
            inv_all   = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checkBit("fill_valid", dout_valid, !abortMiss);
            if (!abortMiss) checkOutput("fill_data", dout, rdata);
            checkBit("fill_memreq", mem_req, 1'b0);
            checkBit("fill_busy", busy, 1'b1);
            md[s]    = rdata;
            mline[s] = addr >> 4;
            mv[s]    = 1'b1;
            if (invFill) modelClear();
            step();
            #1;
            checkBit("after_fill_valid", dout_valid, 1'b0);
            checkBit("after_fill_busy", busy, 1'b0);
        end
    endtask

    // Four hits on consecutive cycles; every address must already be cached.
    task automatic hitBurst(input logic [31:0] addrs [4]);
        cache_rd_en = 1'b1;
        pc_in       = addrs[0];
        step();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) pc_in = addrs[k+1];
            else       cache_rd_en = 1'b0;
            #1;
            checkBit("burst_valid", dout_valid, 1'b1);
            checkOutput("burst_data", dout, md[slotOf(addrs[k])]);
            checkBit("burst_memreq", mem_req, 1'b0);
            step();
        end
        #1;
        checkBit("burst_end_valid", dout_valid, 1'b0);
    endtask

    task automatic pulseInvalidate();
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        modelClear();
    endtask

    initial begin
        logic [31:0] burst [4];
        logic [31:0] a;

        reset       = 1'b1;
        pc_in       = '0;
        cache_rd_en = 1'b0;
        cache_abort = 1'b0;
        inv_all     = 1'b0;
        mem_rdata   = '0;
        mem_valid   = 1'b0;
        modelClear();
        step();
        step();
        checkOutput("reset_dout", dout, '0);
        checkBit("reset_dout_valid", dout_valid, 1'b0);
        checkBit("reset_mem_req", mem_req, 1'b0);
        checkWord("reset_mem_addr", mem_addr, 32'h0);
        checkBit("reset_busy", busy, 1'b0);
        reset = 1'b0;
        step();

        // Cold miss, then a hit on the same line.
        applyStimulus(32'h0000_1040, 3, 1'b0, 1'b0);
        applyStimulus(32'h0000_1048, 0, 1'b0, 1'b0);

        // Back-to-back hits across several lines.
        applyStimulus(32'h0000_1050, 1, 1'b0, 1'b0);
        applyStimulus(32'h0000_1060, 2, 1'b0, 1'b0);
        burst[0] = 32'h0000_1040;
        burst[1] = 32'h0000_1054;
        burst[2] = 32'h0000_1068;
        burst[3] = 32'h0000_104C;
        hitBurst(burst);

        // Conflict at the same index evicts the older line.
        applyStimulus(32'h0000_1440, 2, 1'b0, 1'b0);
        applyStimulus(32'h0000_1040, 1, 1'b0, 1'b0);

        // Abort mid-miss: fill still lands, later request hits.
        applyStimulus(32'h0000_2000, 3, 1'b1, 1'b0);
        applyStimulus(32'h0000_2000, 0, 1'b0, 1'b0);

        // Abort during a hit lookup suppresses the pulse.
        cache_rd_en = 1'b1;
        pc_in       = 32'h0000_2004;
        step();
        cache_rd_en = 1'b0;
        cache_abort = 1'b1;
        #1;
        checkBit("hit_abort_valid", dout_valid, 1'b0);
        step();
        cache_abort = 1'b0;
        #1;
        checkBit("hit_abort_idle_busy", busy, 1'b0);
        checkBit("hit_abort_idle_valid", dout_valid, 1'b0);

        // Abort in the same cycle as the strobe drops the request.
        cache_rd_en = 1'b1;
        cache_abort = 1'b1;
        pc_in       = 32'h0000_2000;
        step();
        cache_rd_en = 1'b0;
        cache_abort = 1'b0;
        #1;
        checkBit("drop_valid", dout_valid, 1'b0);
        checkBit("drop_busy", busy, 1'b0);
        step();
        #1;
        checkBit("drop_valid_later", dout_valid, 1'b0);
        checkBit("drop_memreq", mem_req, 1'b0);

        // Invalidate, then invalidate coincident with a fill.
        applyStimulus(32'h0000_3000, 2, 1'b0, 1'b0);
        pulseInvalidate();
        applyStimulus(32'h0000_3000, 1, 1'b0, 1'b0);
        applyStimulus(32'h0000_3010, 2, 1'b0, 1'b1);
        applyStimulus(32'h0000_3010, 1, 1'b0, 1'b0);

        // Reset while a fill is outstanding.
        cache_rd_en = 1'b1;
        pc_in       = 32'h0000_5000;
        step();
        cache_rd_en = 1'b0;
        step();
        #1;
        checkBit("pre_reset_memreq", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        checkBit("async_reset_memreq", mem_req, 1'b0);
        checkBit("async_reset_valid", dout_valid, 1'b0);
        checkBit("async_reset_busy", busy, 1'b0);
        modelClear();
        step();
        reset = 1'b0;
        step();
        mem_valid = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        step();
        mem_valid = 1'b0;
        #1;
        checkBit("stray_memvalid_valid", dout_valid, 1'b0);
        checkBit("stray_memvalid_busy", busy, 1'b0);
        applyStimulus(32'h0000_5000, 2, 1'b0, 1'b0);

        // Randomised traffic over a few tags and indices to mix hits/misses.
        for (int n = 0; n < 60; n++) begin
            a = 32'h0000_8000
              | (32'($urandom_range(0, 3)) << 10)
              | (32'($urandom_range(0, 7)) << 4)
              | 32'($urandom_range(0, 15));
            applyStimulus(a, int'($urandom_range(1, 4)),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0));
            if ((n % 16) == 15) pulseInvalidate();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
